// File: rtl/prng_lfsr_bank_if.sv
// Valid/ready word stream carrying one random word and the channel that produced it.
interface prng_lfsr_bank_if #(
    parameter int WIDTH = 32,
    parameter int CH_W  = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [CH_W-1:0]  out_ch;

    modport master (output out_valid, output out_data, output out_ch, input out_ready);
    modport slave  (input out_valid, input out_data, input out_ch, output out_ready);
endinterface

// File: rtl/prng_lfsr_bank.sv
// Bank of independent LFSRs (Fibonacci or Galois step) served round-robin
// through a single registered valid/ready output stage with zero-state protection.
module prng_lfsr_bank #(
    parameter int               WIDTH        = 32,
    parameter int               CHANNELS     = 4,
    parameter logic [WIDTH-1:0] TAPS         = WIDTH'(32'h80200003),
    parameter logic [WIDTH-1:0] DEFAULT_SEED = WIDTH'(32'h00000001),
    localparam int              CH_W         = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              mode,
    input  logic              seed_load,
    input  logic [CH_W-1:0]   seed_ch,
    input  logic [WIDTH-1:0]  seed_data,
    prng_lfsr_bank_if.master  out_if,
    output logic [31:0]       word_cnt,
    output logic              lockup
);

    logic [WIDTH-1:0] state [CHANNELS];
    logic [CH_W-1:0]  ptr;

    logic [WIDTH-1:0] cur_state;
    logic [WIDTH-1:0] raw_next;
    logic [WIDTH-1:0] step_next;
    logic [WIDTH-1:0] seed_val;
    logic [CH_W-1:0]  ptr_next;
    logic             step_zero;
    logic             seed_valid;
    logic             seed_zero;
    logic             step_applied;
    logic             load;
    logic             xfer;

    always_comb begin
        cur_state = state[ptr];
        if (mode) begin
            raw_next = {cur_state[WIDTH-2:0], 1'b0} ^ (cur_state[WIDTH-1] ? TAPS : '0);
        end else begin
            raw_next = {cur_state[WIDTH-2:0], ^(cur_state & TAPS)};
        end
        step_zero  = (raw_next == '0);
        step_next  = step_zero ? DEFAULT_SEED : raw_next;

        seed_valid = seed_load && (int'(seed_ch) < CHANNELS);
        seed_zero  = seed_valid && (seed_data == '0);
        seed_val   = (seed_data == '0) ? DEFAULT_SEED : seed_data;

        load       = en && (!out_if.out_valid || out_if.out_ready);
        xfer       = out_if.out_valid && out_if.out_ready;
        // A seed write to the channel being served discards that channel's step.
        step_applied = load && !(seed_valid && (seed_ch == ptr));
        ptr_next   = (int'(ptr) == CHANNELS - 1) ? '0 : ptr + CH_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state[c] <= DEFAULT_SEED ^ WIDTH'(c << 1);
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (seed_valid && (int'(seed_ch) == c)) begin
                    state[c] <= seed_val;
                end else if (load && (int'(ptr) == c)) begin
                    state[c] <= step_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr              <= '0;
            out_if.out_valid <= 1'b0;
            out_if.out_data  <= '0;
            out_if.out_ch    <= '0;
            word_cnt         <= '0;
            lockup           <= 1'b0;
        end else begin
            if (load) begin
                out_if.out_data  <= cur_state;
                out_if.out_ch    <= ptr;
                out_if.out_valid <= 1'b1;
                ptr              <= ptr_next;
            end else if (xfer) begin
                out_if.out_valid <= 1'b0;
            end
            if (xfer) begin
                word_cnt <= word_cnt + 32'd1;
            end
            if (seed_zero || (step_applied && step_zero)) begin
                lockup <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prng_lfsr_bank.sv
// Directed bench for prng_lfsr_bank: default 4x32 bank plus a 4-bit TAPS=0 bank
// that is forced into the all-zero state.
module tb_prng_lfsr_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        en;
    logic        mode;
    logic        seed_load;
    logic [1:0]  seed_ch;
    logic [31:0] seed_data;
    logic [31:0] word_cnt;
    logic        lockup;

    logic        en2;
    logic        seed_load2;
    logic [0:0]  seed_ch2;
    logic [3:0]  seed_data2;
    logic [31:0] word_cnt2;
    logic        lockup2;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    prng_lfsr_bank_if #(.WIDTH(32), .CH_W(2)) bus ();
    prng_lfsr_bank_if #(.WIDTH(4),  .CH_W(1)) bus2 ();

    prng_lfsr_bank dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en),
        .mode      (mode),
        .seed_load (seed_load),
        .seed_ch   (seed_ch),
        .seed_data (seed_data),
        .out_if    (bus),
        .word_cnt  (word_cnt),
        .lockup    (lockup)
    );

    prng_lfsr_bank #(
        .WIDTH        (4),
        .CHANNELS     (2),
        .TAPS         (4'h0),
        .DEFAULT_SEED (4'h1)
    ) dut2 (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (en2),
        .mode      (1'b0),
        .seed_load (seed_load2),
        .seed_ch   (seed_ch2),
        .seed_data (seed_data2),
        .out_if    (bus2),
        .word_cnt  (word_cnt2),
        .lockup    (lockup2)
    );

    task automatic check_output(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Checks the word on offer, then lets one clock edge pass (accepting it if out_ready=1).
    task automatic expect_word(input string tag, input int ch, input logic [31:0] data);
        check_output({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check_output({tag, "_ch"},    64'(bus.out_ch),    64'(ch));
        check_output({tag, "_data"},  64'(bus.out_data),  64'(data));
        @(negedge clk);
    endtask

    task automatic apply_stimulus_reset();
        reset_n       = 1'b0;
        en            = 1'b0;
        seed_load     = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset_n        = 1'b0;
        en             = 1'b0;
        mode           = 1'b0;
        seed_load      = 1'b0;
        seed_ch        = '0;
        seed_data      = '0;
        bus.out_ready  = 1'b1;
        en2            = 1'b0;
        seed_load2     = 1'b0;
        seed_ch2       = '0;
        seed_data2     = '0;
        bus2.out_ready = 1'b1;
        @(negedge clk);

        check_output("rst_valid",   64'(bus.out_valid), 64'd0);
        check_output("rst_data",    64'(bus.out_data),  64'd0);
        check_output("rst_ch",      64'(bus.out_ch),    64'd0);
        check_output("rst_cnt",     64'(word_cnt),      64'd0);
        check_output("rst_lockup",  64'(lockup),        64'd0);
        check_output("rst_lockup2", 64'(lockup2),       64'd0);

        // Free-running Fibonacci stream from reset seeds
        reset_n = 1'b1;
        en      = 1'b1;
        @(negedge clk);
        expect_word("fib0", 0, 32'h1);
        expect_word("fib1", 1, 32'h3);
        expect_word("fib2", 2, 32'h5);
        expect_word("fib3", 3, 32'h7);
        expect_word("fib4", 0, 32'h3);
        expect_word("fib5", 1, 32'h6);
        check_output("fib_cnt", 64'(word_cnt), 64'd6);

        mode = 1'b0;
        apply_stimulus_reset();
        seed_load = 1'b1;
        seed_ch   = 2'd0;
        seed_data = 32'h80000000;
        @(negedge clk);
        seed_load = 1'b0;
        en        = 1'b1;
        @(negedge clk);
        expect_word("sfib0", 0, 32'h80000000);
        expect_word("sfib1", 1, 32'h3);
        expect_word("sfib2", 2, 32'h5);
        expect_word("sfib3", 3, 32'h7);
        expect_word("sfib4", 0, 32'h1);

        mode = 1'b1;
        apply_stimulus_reset();
        seed_load = 1'b1;
        seed_ch   = 2'd0;
        seed_data = 32'h80000000;
        @(negedge clk);
        seed_load = 1'b0;
        en        = 1'b1;
        @(negedge clk);
        expect_word("sgal0", 0, 32'h80000000);
        expect_word("sgal1", 1, 32'h3);
        expect_word("sgal2", 2, 32'h5);
        expect_word("sgal3", 3, 32'h7);
        expect_word("sgal4", 0, 32'h80200003);

        // Backpressure must freeze the held word and the round-robin pointer
        mode = 1'b0;
        apply_stimulus_reset();
        en = 1'b1;
        @(negedge clk);
        expect_word("bp0", 0, 32'h1);
        expect_word("bp1", 1, 32'h3);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_output("bp_hold_valid", 64'(bus.out_valid), 64'd1);
            check_output("bp_hold_ch",    64'(bus.out_ch),    64'd2);
            check_output("bp_hold_data",  64'(bus.out_data),  64'h5);
            check_output("bp_hold_cnt",   64'(word_cnt),      64'd2);
        end
        bus.out_ready = 1'b1;
        expect_word("bp2", 2, 32'h5);
        expect_word("bp3", 3, 32'h7);
        expect_word("bp4", 0, 32'h3);
        expect_word("bp5", 1, 32'h6);
        check_output("bp_cnt", 64'(word_cnt), 64'd6);

        apply_stimulus_reset();
        seed_load = 1'b1;
        seed_ch   = 2'd2;
        seed_data = 32'h0;
        @(negedge clk);
        seed_load = 1'b0;
        check_output("zseed_lockup", 64'(lockup), 64'd1);
        en = 1'b1;
        @(negedge clk);
        expect_word("zs0", 0, 32'h1);
        expect_word("zs1", 1, 32'h3);
        expect_word("zs2", 2, 32'h1);
        expect_word("zs3", 3, 32'h7);

        // Seed write colliding with the load of the same channel
        apply_stimulus_reset();
        en = 1'b1;
        @(negedge clk);
        check_output("col0_ch",   64'(bus.out_ch),   64'd0);
        check_output("col0_data", 64'(bus.out_data), 64'h1);
        seed_load = 1'b1;
        seed_ch   = 2'd1;
        seed_data = 32'h12345678;
        @(negedge clk);
        seed_load = 1'b0;
        expect_word("col1", 1, 32'h3);
        expect_word("col2", 2, 32'h5);
        expect_word("col3", 3, 32'h7);
        expect_word("col4", 0, 32'h3);
        check_output("col5_ch",   64'(bus.out_ch),   64'd1);
        check_output("col5_data", 64'(bus.out_data), 64'h12345678);
        bus.out_ready = 1'b0;
        @(negedge clk);
        check_output("held_valid",  64'(bus.out_valid), 64'd1);
        check_output("held_data",   64'(bus.out_data),  64'h12345678);
        check_output("held_cnt",    64'(word_cnt),      64'd5);
        check_output("held_lockup", 64'(lockup),        64'd0);

        // Asynchronous reset drops the pending word immediately
        reset_n = 1'b0;
        #1;
        check_output("arst_valid", 64'(bus.out_valid), 64'd0);
        check_output("arst_cnt",   64'(word_cnt),      64'd0);
        check_output("arst_data",  64'(bus.out_data),  64'd0);
        @(negedge clk);
        reset_n       = 1'b1;
        en            = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        expect_word("arst_restart", 0, 32'h1);
        en = 1'b0;

        // TAPS=0 bank: seed 0x8 shifts to zero and must be replaced
        seed_load2 = 1'b1;
        seed_ch2   = 1'b0;
        seed_data2 = 4'h8;
        @(negedge clk);
        seed_load2 = 1'b0;
        check_output("z4_pre_lockup", 64'(lockup2), 64'd0);
        en2 = 1'b1;
        @(negedge clk);
        check_output("z4_valid",  64'(bus2.out_valid), 64'd1);
        check_output("z4_ch0",    64'(bus2.out_ch),    64'd0);
        check_output("z4_data0",  64'(bus2.out_data),  64'h8);
        check_output("z4_lockup", 64'(lockup2),        64'd1);
        @(negedge clk);
        check_output("z4_ch1",    64'(bus2.out_ch),    64'd1);
        check_output("z4_data1",  64'(bus2.out_data),  64'h3);
        @(negedge clk);
        check_output("z4_ch0b",   64'(bus2.out_ch),    64'd0);
        check_output("z4_data0b", 64'(bus2.out_data),  64'h1);
        check_output("z4_cnt",    64'(word_cnt2),      64'd2);
        en2 = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
